// File: rtl/noc_route_lut_prog_pkg.sv
// rtl/noc_route_lut_prog_pkg.sv - shared widths, entry layout and route encoding for the routing LUT
`ifndef SOURCEWD
`define SOURCEWD 4
`endif

package noc_route_lut_prog_pkg;

    localparam int SRC_W = `SOURCEWD;

    // Source-routed path: first hop sits in the LSBs, last hop in the MSBs.
    localparam int PATH_W       = 7;
    localparam int NUM_ENTRIES  = 8;
    localparam int IDX_W        = $clog2(NUM_ENTRIES);
    localparam int DEFAULT_PATH = 0;
    localparam int MISS_CNT_W   = 16;

    localparam int ENTRY_W = 1 + SRC_W + PATH_W;

    typedef struct packed {
        logic              en;
        logic [SRC_W-1:0]  src;
        logic [PATH_W-1:0] path;
    } route_entry_t;

endpackage

// File: rtl/noc_route_lut_match.sv
// rtl/noc_route_lut_match.sv - combinational key compare with lowest-index priority select
module noc_route_lut_match
    import noc_route_lut_prog_pkg::*;
#(
    parameter int N_ENT  = NUM_ENTRIES,
    parameter int KEY_W  = SRC_W,
    parameter int PTH_W  = PATH_W,
    parameter int DEF_P  = DEFAULT_PATH
) (
    input  logic [N_ENT-1:0]             i_valid,
    input  logic [N_ENT-1:0][KEY_W-1:0]  i_keys,
    input  logic [N_ENT-1:0][PTH_W-1:0]  i_paths,
    input  logic [KEY_W-1:0]             i_src,
    output logic                         o_hit,
    output logic [PTH_W-1:0]             o_path
);

    // Scan from the top down so the lowest matching index is the last to overwrite
    always_comb begin
        o_hit  = 1'b0;
        o_path = PTH_W'(DEF_P);
        for (int i = N_ENT - 1; i >= 0; i--) begin
            if (i_valid[i] && (i_keys[i] == i_src)) begin
                o_hit  = 1'b1;
                o_path = i_paths[i];
            end
        end
    end

endmodule

// File: rtl/noc_route_lut_prog.sv
// rtl/noc_route_lut_prog.sv - programmable source-ID to route-path table with registered lookup (miss counter under NOC_ROUTE_LUT_MISS_CNT_EN)
module noc_route_lut_prog
    import noc_route_lut_prog_pkg::*;
#(
    parameter int P_SRC_W        = SRC_W,
    parameter int P_PATH_W       = PATH_W,
    parameter int P_NUM_ENTRIES  = NUM_ENTRIES,
    parameter int P_IDX_W        = IDX_W,
    parameter int P_DEFAULT_PATH = DEFAULT_PATH,
    parameter int P_MISS_CNT_W   = MISS_CNT_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cfg_we,
    input  logic [P_IDX_W-1:0]      cfg_idx,
    input  logic [P_SRC_W-1:0]      cfg_src,
    input  logic [P_PATH_W-1:0]     cfg_path,
    input  logic                    cfg_en,
    input  logic                    lkp_valid,
    output logic                    lkp_ready,
    input  logic [P_SRC_W-1:0]      lkp_src,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [P_PATH_W-1:0]     res_path,
    output logic                    res_hit
`ifdef NOC_ROUTE_LUT_MISS_CNT_EN
    ,
    output logic [P_MISS_CNT_W-1:0] miss_count
`endif
);

    logic [P_NUM_ENTRIES-1:0]               r_valid;
    logic [P_NUM_ENTRIES-1:0][P_SRC_W-1:0]  r_key;
    logic [P_NUM_ENTRIES-1:0][P_PATH_W-1:0] r_path;

    logic                r_res_valid;
    logic [P_PATH_W-1:0] r_res_path;
    logic                r_res_hit;

    logic                w_accept;
    logic                w_hit;
    logic [P_PATH_W-1:0] w_path;

    assign lkp_ready = !r_res_valid || res_ready;
    assign w_accept  = lkp_valid && lkp_ready;

    assign res_valid = r_res_valid;
    assign res_path  = r_res_path;
    assign res_hit   = r_res_hit;

    // Lookups compare against the registered table, so a same-cycle write is only seen next cycle
    noc_route_lut_match #(
        .N_ENT (P_NUM_ENTRIES),
        .KEY_W (P_SRC_W),
        .PTH_W (P_PATH_W),
        .DEF_P (P_DEFAULT_PATH)
    ) u_match (
        .i_valid (r_valid),
        .i_keys  (r_key),
        .i_paths (r_path),
        .i_src   (lkp_src),
        .o_hit   (w_hit),
        .o_path  (w_path)
    );

    // Entry valid bits: cleared on reset, rewritten by every config write
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= '0;
        end else if (cfg_we) begin
            r_valid[cfg_idx] <= cfg_en;
        end
    end

    // Key and path storage carry no reset; the valid bit gates their use
    always_ff @(posedge clock) begin
        if (cfg_we) begin
            r_key[cfg_idx]  <= cfg_src;
            r_path[cfg_idx] <= cfg_path;
        end
    end

    // Output stage: EMPTY/FULL held in r_res_valid, result captured on accept and held under backpressure
    always_ff @(posedge clock) begin
        if (reset) begin
            r_res_valid <= 1'b0;
            r_res_path  <= '0;
            r_res_hit   <= 1'b0;
        end else if (w_accept) begin
            r_res_valid <= 1'b1;
            r_res_path  <= w_path;
            r_res_hit   <= w_hit;
        end else if (res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

`ifdef NOC_ROUTE_LUT_MISS_CNT_EN
    logic [P_MISS_CNT_W-1:0] r_miss_count;

    assign miss_count = r_miss_count;

    // Saturating count of accepted lookups that fell through to the default path
    always_ff @(posedge clock) begin
        if (reset) begin
            r_miss_count <= '0;
        end else if (w_accept && !w_hit && (r_miss_count != {P_MISS_CNT_W{1'b1}})) begin
            r_miss_count <= r_miss_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_noc_route_lut_prog.sv
// tb/tb_noc_route_lut_prog.sv - directed self-checking bench for noc_route_lut_prog
`timescale 1ns/1ps
module tb_noc_route_lut_prog;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_idx = '0;
    logic [3:0]  cfg_src = '0;
    logic [6:0]  cfg_path = '0;
    logic        cfg_en = 1'b0;
    logic        lkp_valid = 1'b0;
    logic        lkp_ready;
    logic [3:0]  lkp_src = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [6:0]  res_path;
    logic        res_hit;
`ifdef NOC_ROUTE_LUT_MISS_CNT_EN
    logic [15:0] miss_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    noc_route_lut_prog dut (
        .clock     (clock),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_src   (cfg_src),
        .cfg_path  (cfg_path),
        .cfg_en    (cfg_en),
        .lkp_valid (lkp_valid),
        .lkp_ready (lkp_ready),
        .lkp_src   (lkp_src),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_path  (res_path),
        .res_hit   (res_hit)
`ifdef NOC_ROUTE_LUT_MISS_CNT_EN
        ,
        .miss_count (miss_count)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] idx, input logic en, input logic [3:0] src, input logic [6:0] path);
        cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_src = src; cfg_path = path;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        #1;
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", res_valid); end
        n_cmp++; if (res_path !== 7'd0) begin n_err++; $display("FAIL reset_path: got %b want 0000000", res_path); end
        n_cmp++; if (res_hit !== 1'b0) begin n_err++; $display("FAIL reset_hit: got %b want 0", res_hit); end
        n_cmp++; if (lkp_ready !== 1'b1) begin n_err++; $display("FAIL reset_lkp_ready: got %b want 1", lkp_ready); end
`ifdef NOC_ROUTE_LUT_MISS_CNT_EN
        n_cmp++; if (miss_count !== 16'd0) begin n_err++; $display("FAIL reset_miss_count: got %0d want 0", miss_count); end
`endif
    endtask

    task automatic test_miss_default();
        res_ready = 1'b0;
        lkp_valid = 1'b1; lkp_src = 4'h9;
        step();
        lkp_valid = 1'b0;
        n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL miss_valid: got %b want 1", res_valid); end
        n_cmp++; if (res_hit !== 1'b0) begin n_err++; $display("FAIL miss_hit: got %b want 0", res_hit); end
        n_cmp++; if (res_path !== 7'd0) begin n_err++; $display("FAIL miss_path: got %b want 0000000", res_path); end
`ifdef NOC_ROUTE_LUT_MISS_CNT_EN
        n_cmp++; if (miss_count !== 16'd1) begin n_err++; $display("FAIL miss_count_1: got %0d want 1", miss_count); end
`endif
        res_ready = 1'b1;
        step();
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL miss_drain: got %b want 0", res_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] srcs  [4] = '{4'h9, 4'h0, 4'hd, 4'h3};
        logic [6:0] paths [4] = '{7'b0000011, 7'b0000101, 7'b0011101, 7'b0000000};
        logic       hits  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        cfg_write(3'd0, 1'b1, 4'h9, 7'b0000011);
        cfg_write(3'd1, 1'b1, 4'h0, 7'b0000101);
        cfg_write(3'd2, 1'b1, 4'hd, 7'b0011101);
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lkp_valid = 1'b1; lkp_src = srcs[i];
            step();
            n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, res_valid); end
            n_cmp++; if (res_path !== paths[i]) begin n_err++; $display("FAIL b2b_path[%0d]: got %b want %b", i, res_path, paths[i]); end
            n_cmp++; if (res_hit !== hits[i]) begin n_err++; $display("FAIL b2b_hit[%0d]: got %b want %b", i, res_hit, hits[i]); end
        end
        lkp_valid = 1'b0;
        step();
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", res_valid); end
`ifdef NOC_ROUTE_LUT_MISS_CNT_EN
        n_cmp++; if (miss_count !== 16'd2) begin n_err++; $display("FAIL miss_count_2: got %0d want 2", miss_count); end
`endif
    endtask

    task automatic test_duplicate_key();
        cfg_write(3'd5, 1'b1, 4'hd, 7'h7f);
        res_ready = 1'b1;
        lkp_valid = 1'b1; lkp_src = 4'hd;
        step();
        lkp_valid = 1'b0;
        n_cmp++; if (res_path !== 7'b0011101 || res_hit !== 1'b1) begin n_err++; $display("FAIL dup_lowest: got path %b hit %b want 0011101 1", res_path, res_hit); end
        cfg_write(3'd2, 1'b0, 4'hd, 7'b0011101);
        lkp_valid = 1'b1; lkp_src = 4'hd;
        step();
        lkp_valid = 1'b0;
        n_cmp++; if (res_path !== 7'h7f || res_hit !== 1'b1) begin n_err++; $display("FAIL dup_invalidated: got path %b hit %b want 1111111 1", res_path, res_hit); end
        step();
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        lkp_valid = 1'b1; lkp_src = 4'h0;
        step();
        lkp_src = 4'h9;
        n_cmp++; if (res_path !== 7'b0000101 || res_valid !== 1'b1) begin n_err++; $display("FAIL bp_first: got path %b valid %b want 0000101 1", res_path, res_valid); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (lkp_ready !== 1'b0) begin n_err++; $display("FAIL bp_lkp_ready[%0d]: got %b want 0", i, lkp_ready); end
            step();
            n_cmp++; if (res_path !== 7'b0000101 || res_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold[%0d]: got path %b valid %b want 0000101 1", i, res_path, res_valid); end
        end
        res_ready = 1'b1;
        #1;
        n_cmp++; if (lkp_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", lkp_ready); end
        step();
        lkp_valid = 1'b0;
        n_cmp++; if (res_path !== 7'b0000011 || res_valid !== 1'b1) begin n_err++; $display("FAIL bp_accept: got path %b valid %b want 0000011 1", res_path, res_valid); end
        step();
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b want 0", res_valid); end
    endtask

    task automatic test_collision();
        res_ready = 1'b1;
        cfg_we = 1'b1; cfg_idx = 3'd0; cfg_en = 1'b1; cfg_src = 4'h9; cfg_path = 7'h11;
        lkp_valid = 1'b1; lkp_src = 4'h9;
        step();
        cfg_we = 1'b0;
        n_cmp++; if (res_path !== 7'b0000011) begin n_err++; $display("FAIL collide_old: got %b want 0000011", res_path); end
        step();
        lkp_valid = 1'b0;
        n_cmp++; if (res_path !== 7'h11 || res_hit !== 1'b1) begin n_err++; $display("FAIL collide_new: got path %b hit %b want 0010001 1", res_path, res_hit); end
        step();
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b0;
        lkp_valid = 1'b1; lkp_src = 4'h9;
        step();
        n_cmp++; if (res_valid !== 1'b1 || res_path !== 7'h11) begin n_err++; $display("FAIL rst_pending: got valid %b path %b want 1 0010001", res_valid, res_path); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rst_drop: got %b want 0", res_valid); end
`ifdef NOC_ROUTE_LUT_MISS_CNT_EN
        n_cmp++; if (miss_count !== 16'd0) begin n_err++; $display("FAIL rst_miss_clear: got %0d want 0", miss_count); end
`endif
        step();
        lkp_valid = 1'b0;
        n_cmp++; if (res_valid !== 1'b1 || res_hit !== 1'b0 || res_path !== 7'd0) begin n_err++; $display("FAIL rst_table_cleared: got valid %b hit %b path %b want 1 0 0000000", res_valid, res_hit, res_path); end
`ifdef NOC_ROUTE_LUT_MISS_CNT_EN
        n_cmp++; if (miss_count !== 16'd1) begin n_err++; $display("FAIL rst_miss_count: got %0d want 1", miss_count); end
`endif
        res_ready = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_miss_default();
        test_back_to_back();
        test_duplicate_key();
        test_backpressure();
        test_collision();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
